// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, control-byte fields and bit-phase encoding.
// Used by eeprom_seq_rd and the EEPROM page-write block.
package i2c_pkg;

   localparam logic [3:0] CTRL_CODE = 4'b1010;
   localparam logic       RW_WR     = 1'b0;
   localparam logic       RW_RD     = 1'b1;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } phase_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_WR_CTRL,
      ST_ACK_CTRL,
      ST_WR_AH,
      ST_ACK_AH,
      ST_WR_AL,
      ST_ACK_AL,
      ST_RSTART,
      ST_RD_CTRL,
      ST_ACK_RD,
      ST_RD_BYTE,
      ST_M_ACK,
      ST_STOP,
      ST_DONE,
      ST_POLL_WAIT
   } i2c_state_e;

   function automatic logic [7:0] ctrl_byte(input logic [2:0] dev, input logic rw);
      return {CTRL_CODE, dev, rw};
   endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit tick and phase generator. Phase rests at P3 while disabled so the
// first tick after enable lands on P0; tick marks the cycle a new phase begins.
module i2c_qtr_tick
   import i2c_pkg::*;
#(
   parameter int unsigned QTR = 125
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en_i,
   output logic   tick_o,
   output phase_e phase_o
);

   localparam int unsigned CNT_W = (QTR > 1) ? $clog2(QTR) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic             wrap;

   assign wrap = (cnt_q == CNT_W'(QTR - 1));

   always_ff @(posedge clk) begin
      if (rst || !en_i) begin
         cnt_q   <= '0;
         tick_o  <= 1'b0;
         phase_o <= P3;
      end else begin
         tick_o <= wrap;
         if (wrap) begin
            cnt_q   <= '0;
            phase_o <= phase_e'(phase_o + 2'd1);
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/eeprom_seq_rd.sv
// I2C sequential-read master for the 24LC64: dummy address write, repeated START,
// N-byte read, master NACK, STOP. Define EEPROM_ACK_POLL_EN to retry a control-byte NACK.
module eeprom_seq_rd
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned I2C_FREQ = 100_000,
   parameter logic [2:0]  DEV_SEL  = 3'b000,
   parameter int unsigned LEN_W    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [12:0]      mem_addr,
   input  logic [LEN_W-1:0] rd_len,
   output logic             busy,
   output logic             done,
   output logic             ack_err,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             scl,
   inout  wire              sda
);

   localparam int unsigned QTR = CLK_FREQ / (4 * I2C_FREQ);

   i2c_state_e       state_q;
   logic [12:0]      addr_q;
   logic [LEN_W-1:0] remain_q;
   logic [2:0]       bit_q;
   logic [7:0]       sh_q;
   logic             nack_q;
   logic             sda_oe_q;
   logic             sda_s1_q;
   logic             sda_s2_q;
   logic             tick;
   phase_e           phase;
`ifdef EEPROM_ACK_POLL_EN
   logic [7:0]       retry_q;
   logic             poll_q;
`endif

   // Open-drain: only ever pull low.
   assign sda = sda_oe_q ? 1'b0 : 1'bz;

   i2c_qtr_tick #(
      .QTR(QTR)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en_i   (busy),
      .tick_o (tick),
      .phase_o(phase)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         nack_q   <= 1'b0;
         sda_oe_q <= 1'b0;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         ack_err  <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         scl      <= 1'b1;
`ifdef EEPROM_ACK_POLL_EN
         retry_q  <= '0;
         poll_q   <= 1'b0;
`endif
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         sda_s1_q <= sda;
         sda_s2_q <= sda_s1_q;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  ack_err  <= 1'b0;
                  addr_q   <= mem_addr;
                  remain_q <= rd_len;
                  busy     <= 1'b1;
                  state_q  <= (rd_len == '0) ? ST_DONE : ST_START;
`ifdef EEPROM_ACK_POLL_EN
                  retry_q  <= '0;
                  poll_q   <= 1'b0;
`endif
               end
            end

            ST_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               if (tick) begin
                  case (phase)
                     // P0: SCL is low, set up SDA for this bit.
                     P0: begin
                        case (state_q)
                           ST_WR_CTRL, ST_WR_AH, ST_WR_AL, ST_RD_CTRL: sda_oe_q <= ~sh_q[7];
                           ST_M_ACK:     sda_oe_q <= (remain_q != '0);
                           ST_STOP:      sda_oe_q <= 1'b1;
                           ST_POLL_WAIT: sda_oe_q <= 1'b0;
                           default:      sda_oe_q <= 1'b0;
                        endcase
                     end

                     P1: scl <= 1'b1;

                     // P2: SCL high; START/STOP edges and slave-data sampling.
                     P2: begin
                        case (state_q)
                           ST_START, ST_RSTART: sda_oe_q <= 1'b1;
                           ST_STOP:             sda_oe_q <= 1'b0;
                           ST_ACK_CTRL, ST_ACK_AH, ST_ACK_AL, ST_ACK_RD: nack_q <= sda_s2_q;
                           ST_RD_BYTE: begin
                              sh_q <= {sh_q[6:0], sda_s2_q};
                              if (bit_q == 3'd0) begin
                                 rd_data  <= {sh_q[6:0], sda_s2_q};
                                 rd_valid <= 1'b1;
                              end
                           end
                           default: ;
                        endcase
                     end

                     // P3: end of bit; SCL falls except after STOP, and the state advances.
                     P3: begin
                        case (state_q)
                           ST_START: begin
                              scl     <= 1'b0;
                              sh_q    <= ctrl_byte(DEV_SEL, RW_WR);
                              bit_q   <= 3'd7;
                              state_q <= ST_WR_CTRL;
                           end
                           ST_WR_CTRL, ST_WR_AH, ST_WR_AL, ST_RD_CTRL: begin
                              scl <= 1'b0;
                              if (bit_q == 3'd0) begin
                                 case (state_q)
                                    ST_WR_CTRL: state_q <= ST_ACK_CTRL;
                                    ST_WR_AH:   state_q <= ST_ACK_AH;
                                    ST_WR_AL:   state_q <= ST_ACK_AL;
                                    default:    state_q <= ST_ACK_RD;
                                 endcase
                              end else begin
                                 bit_q <= bit_q - 3'd1;
                                 sh_q  <= {sh_q[6:0], 1'b0};
                              end
                           end
                           ST_ACK_CTRL: begin
                              scl <= 1'b0;
                              if (nack_q) begin
`ifdef EEPROM_ACK_POLL_EN
                                 if (retry_q != 8'd255) begin
                                    retry_q <= retry_q + 8'd1;
                                    poll_q  <= 1'b1;
                                 end else begin
                                    ack_err <= 1'b1;
                                 end
`else
                                 ack_err <= 1'b1;
`endif
                                 state_q <= ST_STOP;
                              end else begin
                                 sh_q    <= {3'b000, addr_q[12:8]};
                                 bit_q   <= 3'd7;
                                 state_q <= ST_WR_AH;
                              end
                           end
                           ST_ACK_AH: begin
                              scl <= 1'b0;
                              if (nack_q) begin
                                 ack_err <= 1'b1;
                                 state_q <= ST_STOP;
                              end else begin
                                 sh_q    <= addr_q[7:0];
                                 bit_q   <= 3'd7;
                                 state_q <= ST_WR_AL;
                              end
                           end
                           ST_ACK_AL: begin
                              scl <= 1'b0;
                              if (nack_q) begin
                                 ack_err <= 1'b1;
                                 state_q <= ST_STOP;
                              end else begin
                                 state_q <= ST_RSTART;
                              end
                           end
                           ST_RSTART: begin
                              scl     <= 1'b0;
                              sh_q    <= ctrl_byte(DEV_SEL, RW_RD);
                              bit_q   <= 3'd7;
                              state_q <= ST_RD_CTRL;
                           end
                           ST_ACK_RD: begin
                              scl <= 1'b0;
                              if (nack_q) begin
                                 ack_err <= 1'b1;
                                 state_q <= ST_STOP;
                              end else begin
                                 bit_q   <= 3'd7;
                                 state_q <= ST_RD_BYTE;
                              end
                           end
                           ST_RD_BYTE: begin
                              scl <= 1'b0;
                              if (bit_q == 3'd0) begin
                                 remain_q <= remain_q - LEN_W'(1);
                                 state_q  <= ST_M_ACK;
                              end else begin
                                 bit_q <= bit_q - 3'd1;
                              end
                           end
                           ST_M_ACK: begin
                              scl <= 1'b0;
                              if (remain_q != '0) begin
                                 bit_q   <= 3'd7;
                                 state_q <= ST_RD_BYTE;
                              end else begin
                                 state_q <= ST_STOP;
                              end
                           end
                           ST_STOP: begin
`ifdef EEPROM_ACK_POLL_EN
                              if (poll_q) begin
                                 poll_q  <= 1'b0;
                                 state_q <= ST_POLL_WAIT;
                              end else begin
                                 state_q <= ST_DONE;
                              end
`else
                              state_q <= ST_DONE;
`endif
                           end
                           ST_POLL_WAIT: state_q <= ST_START;
                           default:      state_q <= ST_IDLE;
                        endcase
                     end

                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_seq_rd.sv
// Directed bench for eeprom_seq_rd with a behavioural 24LC64 slave on the bus.
// A second instance with a mismatched chip select exercises the control-byte NACK path.
module tb_eeprom_seq_rd;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start1;
   logic [12:0] mem_addr;
   logic [5:0]  rd_len;
   logic        busy, done, ack_err, rd_valid, scl;
   logic [7:0]  rd_data;
   logic        busy1, done1, ack_err1, rd_valid1, scl1;
   logic [7:0]  rd_data1;
   wire         sda;
   wire         sda1;

   int tests = 0;
   int fails = 0;

   pullup (sda);
   pullup (sda1);

   always #5 clk = ~clk;

   eeprom_seq_rd #(
      .CLK_FREQ(1_600_000), .I2C_FREQ(100_000), .DEV_SEL(3'b000), .LEN_W(6)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .rd_len(rd_len),
      .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data),
      .rd_valid(rd_valid), .scl(scl), .sda(sda)
   );

   eeprom_seq_rd #(
      .CLK_FREQ(1_600_000), .I2C_FREQ(200_000), .DEV_SEL(3'b001), .LEN_W(6)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .mem_addr(mem_addr), .rd_len(rd_len),
      .busy(busy1), .done(done1), .ack_err(ack_err1), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .scl(scl1), .sda(sda1)
   );

   // Behavioural 24LC64 strapped to A2..A0 = 000, sampled on the system clock.
   logic [7:0]  mem [0:8191];
   logic        s_drv = 1'b0;
   logic        ps_scl = 1'b1, ps_sda = 1'b1;
   int          s_mode = 0;
   int          s_bc = 0;
   logic [7:0]  s_sh = '0, s_tx = '0;
   logic [12:0] s_ptr = '0, s_nptr;
   logic        s_rd = 1'b0, s_after = 1'b0, s_mack = 1'b0;
   int          stops_seen = 0;
   int          nack_given = 0;
   int          poll_limit = 0;

   assign sda    = s_drv ? 1'b0 : 1'bz;
   assign s_nptr = s_ptr + 13'd1;

   always @(posedge clk) begin
      ps_scl <= scl;
      ps_sda <= sda;
      if (rst) begin
         s_mode <= 0;
         s_drv  <= 1'b0;
      end else if (ps_scl && scl && ps_sda && !sda) begin
         s_mode  <= 1;
         s_bc    <= 0;
         s_after <= 1'b1;
         s_drv   <= 1'b0;
      end else if (ps_scl && scl && !ps_sda && sda) begin
         s_mode     <= 0;
         s_drv      <= 1'b0;
         stops_seen <= stops_seen + 1;
      end else if (!ps_scl && scl) begin
         if (s_mode >= 1 && s_mode <= 4 && s_bc < 8) s_sh <= {s_sh[6:0], sda};
         if (s_mode == 5 && s_bc == 8) s_mack <= sda;
      end else if (ps_scl && !scl) begin
         if (s_after) begin
            s_after <= 1'b0;
         end else if (s_mode != 0) begin
            if (s_bc < 7) begin
               s_bc <= s_bc + 1;
               if (s_mode == 5) s_drv <= ~s_tx[6 - s_bc];
            end else if (s_bc == 7) begin
               s_bc <= 8;
               case (s_mode)
                  5: s_drv <= 1'b0;
                  1: begin
                     if (s_sh[7:1] == 7'b1010000 && nack_given >= poll_limit) begin
                        s_drv <= 1'b1;
                        s_rd  <= s_sh[0];
                     end else begin
                        if (s_sh[7:1] == 7'b1010000) nack_given <= nack_given + 1;
                        s_mode <= 0;
                        s_drv  <= 1'b0;
                     end
                  end
                  2: begin s_ptr[12:8] <= s_sh[4:0]; s_drv <= 1'b1; end
                  3: begin s_ptr[7:0] <= s_sh; s_drv <= 1'b1; end
                  default: s_drv <= 1'b1;
               endcase
            end else begin
               s_bc  <= 0;
               s_drv <= 1'b0;
               case (s_mode)
                  5: begin
                     if (!s_mack) begin
                        s_ptr <= s_nptr;
                        s_tx  <= mem[s_nptr];
                        s_drv <= ~mem[s_nptr][7];
                     end else begin
                        s_mode <= 0;
                     end
                  end
                  1: begin
                     if (s_rd) begin
                        s_mode <= 5;
                        s_tx   <= mem[s_ptr];
                        s_drv  <= ~mem[s_ptr][7];
                     end else begin
                        s_mode <= 2;
                     end
                  end
                  2: s_mode <= 3;
                  default: s_mode <= 4;
               endcase
            end
         end
      end
   end

   logic [7:0] rx_q[$];
   int         rv1_cnt = 0;

   always @(negedge clk) begin
      if (rd_valid) rx_q.push_back(rd_data);
      if (rd_valid1) rv1_cnt <= rv1_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one read on the main instance and wait (bounded) for done.
   task automatic do_read(input logic [12:0] a, input logic [5:0] n, output int cyc);
      rx_q.delete();
      @(negedge clk);
      mem_addr = a;
      rd_len   = n;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_timeout", 32'(cyc < 20000), 32'd1);
   endtask

   initial begin
      int         cyc;
      int         st0;
      logic [7:0] exp_w [4];
      logic       bus_idle;

      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
      mem[13'h1FFE] = 8'hAA;
      mem[13'h1FFF] = 8'hBB;
      exp_w = '{8'hAA, 8'hBB, 8'h00, 8'h01};

      rst = 1'b1; start = 1'b0; start1 = 1'b0; mem_addr = '0; rd_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ack_err", 32'(ack_err), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_scl", 32'(scl), 32'd1);
      chk("rst_sda", 32'(sda), 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic 4-byte read from 0x0000.
      st0 = stops_seen;
      do_read(13'h0000, 6'd4, cyc);
      chk("rd4_count", 32'(rx_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("rd4_byte", 32'(rx_q[i]), 32'(i));
      chk("rd4_ack_err", 32'(ack_err), 32'd0);
      chk("rd4_busy_at_done", 32'(busy), 32'd0);
      chk("rd4_master_nack", 32'(s_mack), 32'd1);
      chk("rd4_stop", 32'(stops_seen - st0), 32'd1);
      chk("rd4_scl_idle", 32'(scl), 32'd1);
      chk("rd4_sda_idle", 32'(sda), 32'd1);
      @(negedge clk);
      chk("rd4_done_pulse", 32'(done), 32'd0);

      // Read across the top of the array; the slave wraps to 0x0000.
      do_read(13'h1FFE, 6'd4, cyc);
      chk("wrap_count", 32'(rx_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("wrap_byte", 32'(rx_q[i]), 32'(exp_w[i]));
      chk("wrap_ack_err", 32'(ack_err), 32'd0);

      // Chip select mismatch: no device answers, control byte NACKed.
      @(negedge clk);
      mem_addr = 13'h0000;
      rd_len   = 6'd4;
      start1   = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      cyc    = 1;
      while (done1 !== 1'b1 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
      end
      chk("nack_done", 32'(cyc < 60000), 32'd1);
      chk("nack_ack_err", 32'(ack_err1), 32'd1);
      chk("nack_no_valid", 32'(rv1_cnt), 32'd0);
      chk("nack_scl", 32'(scl1), 32'd1);
      chk("nack_sda", 32'(sda1), 32'd1);

      // Zero-length request: done two clocks after start, bus untouched.
      @(negedge clk);
      mem_addr = 13'h0005;
      rd_len   = 6'd0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("len0_busy1", 32'(busy), 32'd1);
      chk("len0_done1", 32'(done), 32'd0);
      bus_idle = scl & sda;
      @(negedge clk);
      chk("len0_done2", 32'(done), 32'd1);
      chk("len0_busy2", 32'(busy), 32'd0);
      bus_idle = bus_idle & scl & sda;
      @(negedge clk);
      chk("len0_done3", 32'(done), 32'd0);
      bus_idle = bus_idle & scl & sda;
      chk("len0_bus_idle", 32'(bus_idle), 32'd1);

      // Reset in the middle of the second data byte, then a clean 2-byte read.
      rx_q.delete();
      @(negedge clk);
      mem_addr = 13'h0008;
      rd_len   = 6'd4;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (rx_q.size() == 0 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_first_byte", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hFF), 32'h08);
      repeat (40) @(negedge clk);
      chk("mid_still_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_scl", 32'(scl), 32'd1);
      chk("mid_sda", 32'(sda), 32'd1);
      repeat (4) @(negedge clk);
      do_read(13'h0010, 6'd2, cyc);
      chk("post_rst_count", 32'(rx_q.size()), 32'd2);
      for (int i = 0; i < 2; i++) chk("post_rst_byte", 32'(rx_q[i]), 32'(16 + i));
      chk("post_rst_ack_err", 32'(ack_err), 32'd0);

`ifdef EEPROM_ACK_POLL_EN
      // Device busy with its write cycle: NACKs the first three control bytes.
      for (int i = 0; i < 4; i++) mem[13'h0100 + 13'(i)] = 8'hC0 + 8'(i);
      poll_limit = nack_given + 3;
      do_read(13'h0100, 6'd4, cyc);
      chk("poll_count", 32'(rx_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("poll_byte", 32'(rx_q[i]), 32'hC0 + 32'(i));
      chk("poll_ack_err", 32'(ack_err), 32'd0);
      chk("poll_nacks", 32'(nack_given), 32'(poll_limit));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
